// File: rtl/fpu_link_pkg.sv
// fpu_link_pkg: shared state encoding, widths and half-word helpers for the FPU stb/ack link masters.
package fpu_link_pkg;
  localparam int LINK_W = 16;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {
    S_IDLE, S_A_HI, S_A_LO, S_B_HI, S_B_LO, S_Z_HI, S_Z_LO, S_RESULT
  } state_e;
  function automatic logic [LINK_W-1:0] hi(input logic [WORD_W-1:0] w);
    return w[WORD_W-1:LINK_W];
  endfunction
  function automatic logic [LINK_W-1:0] lo(input logic [WORD_W-1:0] w);
    return w[LINK_W-1:0];
  endfunction
endpackage

// File: rtl/link_word_tx.sv
// link_word_tx: holds one outgoing 16-bit link word with its strobe and flags the transfer.
module link_word_tx
  import fpu_link_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [LINK_W-1:0] word_i,
  input  logic              ack_i,
  output logic [LINK_W-1:0] word_o,
  output logic              stb_o,
  output logic              xfer_o
);
  logic [LINK_W-1:0] word_q, word_d;
  logic              stb_q, stb_d;
  always_comb begin
    word_d = load_i ? word_i : word_q;
    stb_d  = load_i ? 1'b1 : drop_i ? 1'b0 : stb_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      stb_q  <= stb_d;
    end
  end
  assign word_o = word_q;
  assign stb_o  = stb_q;
  assign xfer_o = stb_q && ack_i;
endmodule

// File: rtl/divider_link_master.sv
// divider_link_master: sends a 32-bit operand pair as four 16-bit stb/ack words and collects the two-word result.
module divider_link_master
  import fpu_link_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WORD_W-1:0] cmd_a_i,
  input  logic [WORD_W-1:0] cmd_b_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  output logic [LINK_W-1:0] link_a_o,
  output logic              link_a_stb_o,
  input  logic              link_a_ack_i,
  output logic [LINK_W-1:0] link_b_o,
  output logic              link_b_stb_o,
  input  logic              link_b_ack_i,
  input  logic [LINK_W-1:0] link_z_i,
  input  logic              link_z_stb_i,
  output logic              link_z_ack_o,
  output logic [WORD_W-1:0] res_z_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              timeout_o
);
  state_e            state_q, state_d;
  logic [WORD_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [15:0]       wd_q, wd_d;
  logic              cmd_ready_q, cmd_ready_d, z_ack_q, z_ack_d;
  logic              res_valid_q, res_valid_d, to_q, to_d;
  logic              accept, active, z_xfer;
  logic              a_load, a_drop, a_xfer, b_load, b_drop, b_xfer;
  logic [LINK_W-1:0] a_word, b_word;

  link_word_tx u_tx_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(a_load), .drop_i(a_drop), .word_i(a_word),
    .ack_i(link_a_ack_i), .word_o(link_a_o), .stb_o(link_a_stb_o), .xfer_o(a_xfer)
  );
  link_word_tx u_tx_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(b_load), .drop_i(b_drop), .word_i(b_word),
    .ack_i(link_b_ack_i), .word_o(link_b_o), .stb_o(link_b_stb_o), .xfer_o(b_xfer)
  );

  always_comb begin
    accept      = cmd_valid_i && cmd_ready_q;
    z_xfer      = link_z_stb_i && z_ack_q;
    active      = state_q != S_IDLE && state_q != S_RESULT;
    state_d     = state_q;
    a_d         = accept ? cmd_a_i : a_q;
    b_d         = accept ? cmd_b_i : b_q;
    res_d       = res_q;
    z_ack_d     = z_ack_q;
    res_valid_d = res_valid_q;
    a_load      = 1'b0;
    a_drop      = 1'b0;
    a_word      = hi(cmd_a_i);
    b_load      = 1'b0;
    b_drop      = 1'b0;
    b_word      = hi(b_q);
    unique case (state_q)
      S_IDLE: begin
        a_load  = accept;
        state_d = accept ? S_A_HI : S_IDLE;
      end
      S_A_HI: begin
        a_load  = a_xfer;
        a_word  = lo(a_q);
        state_d = a_xfer ? S_A_LO : S_A_HI;
      end
      S_A_LO: begin
        a_drop  = a_xfer;
        b_load  = a_xfer;
        state_d = a_xfer ? S_B_HI : S_A_LO;
      end
      S_B_HI: begin
        b_load  = b_xfer;
        b_word  = lo(b_q);
        state_d = b_xfer ? S_B_LO : S_B_HI;
      end
      S_B_LO: begin
        b_drop  = b_xfer;
        z_ack_d = z_ack_q || b_xfer;
        state_d = b_xfer ? S_Z_HI : S_B_LO;
      end
      S_Z_HI: begin
        res_d   = z_xfer ? {link_z_i, res_q[LINK_W-1:0]} : res_q;
        state_d = z_xfer ? S_Z_LO : S_Z_HI;
      end
      S_Z_LO: begin
        res_d       = z_xfer ? {res_q[WORD_W-1:LINK_W], link_z_i} : res_q;
        z_ack_d     = !z_xfer;
        res_valid_d = z_xfer;
        state_d     = z_xfer ? S_RESULT : S_Z_LO;
      end
      default: begin
        res_valid_d = !res_ready_i;
        state_d     = res_ready_i ? S_IDLE : S_RESULT;
      end
    endcase
    // cmd_ready only rises after a full cycle in IDLE, giving the mandatory idle gap
    cmd_ready_d = state_q == S_IDLE && !accept;
    wd_d        = accept ? 16'd0 : (active && wd_q != 16'hFFFF) ? wd_q + 16'd1 : wd_q;
    to_d        = accept ? 1'b0 : to_q || (active && wd_d == 16'(TIMEOUT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      wd_q        <= '0;
      cmd_ready_q <= 1'b0;
      z_ack_q     <= 1'b0;
      res_valid_q <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      wd_q        <= wd_d;
      cmd_ready_q <= cmd_ready_d;
      z_ack_q     <= z_ack_d;
      res_valid_q <= res_valid_d;
      to_q        <= to_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign link_z_ack_o = z_ack_q;
  assign res_z_o      = res_q;
  assign res_valid_o  = res_valid_q;
  assign timeout_o    = to_q;
endmodule

// File: tb/tb_divider_link_master.sv
// tb_divider_link_master: directed vectors through divider_link_master against a behavioural link responder.
module tb_divider_link_master;
  logic        clk = 1'b0, rst_n;
  logic [31:0] cmd_a, cmd_b, res_z, z_word;
  logic        cmd_valid, cmd_ready, res_valid, res_ready, timeout;
  logic [15:0] link_a, link_b, link_z, saved;
  logic        link_a_stb, link_a_ack, link_b_stb, link_b_ack, link_z_stb, link_z_ack;
  logic [15:0] rx [4];
  int          n_cmp = 0, n_bad = 0, rp, cnt, ack_dly, stab_err;
  logic        z_en;

  typedef struct {
    logic [31:0] a, b, z;
    int          dly;
    logic        to;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  divider_link_master #(.TIMEOUT(20)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready), .link_a_o(link_a), .link_a_stb_o(link_a_stb), .link_a_ack_i(link_a_ack),
    .link_b_o(link_b), .link_b_stb_o(link_b_stb), .link_b_ack_i(link_b_ack), .link_z_i(link_z),
    .link_z_stb_i(link_z_stb), .link_z_ack_o(link_z_ack), .res_z_o(res_z), .res_valid_o(res_valid),
    .res_ready_i(res_ready), .timeout_o(timeout)
  );

  // Core-side responder: acks each send word after ack_dly stable cycles, then returns z_word in two words.
  initial begin
    logic        s;
    logic [15:0] w;
    rp = 0; cnt = 0; stab_err = 0; saved = '0;
    link_a_ack = 1'b0; link_b_ack = 1'b0; link_z = '0; link_z_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rp = 0; cnt = 0; link_a_ack = 1'b0; link_b_ack = 1'b0; link_z_stb = 1'b0;
      end else if (rp < 4) begin
        s = rp < 2 ? link_a_stb : link_b_stb;
        w = rp < 2 ? link_a : link_b;
        if (link_a_ack || link_b_ack) begin
          rx[rp] = saved; link_a_ack = 1'b0; link_b_ack = 1'b0; rp++; cnt = 0;
        end else if (s) begin
          if (cnt > 0 && w !== saved) stab_err++;
          saved = w;
          if (cnt >= ack_dly) begin
            if (rp < 2) link_a_ack = 1'b1;
            else link_b_ack = 1'b1;
          end else cnt++;
        end
      end else if (rp == 4) begin
        if (link_z_ack && z_en) begin link_z = z_word[31:16]; link_z_stb = 1'b1; rp = 5; end
      end else if (rp == 5) begin
        link_z_stb = 1'b0; rp = 6;
      end else if (rp == 6) begin
        link_z = z_word[15:0]; link_z_stb = 1'b1; rp = 7;
      end else begin
        link_z_stb = 1'b0; rp = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start(input vec_t v);
    int n = 0;
    ack_dly = v.dly; z_word = v.z; z_en = 1'b1;
    cmd_a = v.a; cmd_b = v.b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", {79'd0, cmd_ready}, 80'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic collect(input vec_t v);
    int n = 0;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    chk("res_valid_wait", {79'd0, res_valid}, 80'd1);
    chk("res_z", {48'd0, res_z}, {48'd0, v.z});
    chk("word_order", {16'd0, rx[0], rx[1], rx[2], rx[3]}, {16'd0, v.a, v.b});
    chk("timeout", {79'd0, timeout}, {79'd0, v.to});
    chk("word_stable", 80'(stab_err), 80'd0);
  endtask

  task automatic handoff(input vec_t v);
    repeat (2) begin
      @(negedge clk);
      chk("res_hold", {47'd0, res_valid, res_z}, {47'd0, 1'b1, v.z});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_release", {78'd0, res_valid, cmd_ready}, 80'd0);
    @(negedge clk);
    chk("idle_ready", {79'd0, cmd_ready}, 80'd1);
  endtask

  task automatic all_zero(input string nm);
    chk(nm, {10'd0, cmd_ready, link_a, link_a_stb, link_b, link_b_stb, link_z_ack, res_z, res_valid, timeout}, 80'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 0, 1'b0};
    vecs[1] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1, 1'b0};
    vecs[2] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 5, 1'b1};
    vecs[3] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 0, 1'b0};
    rst_n = 1'b0; cmd_a = '0; cmd_b = '0; cmd_valid = 1'b0; res_ready = 1'b0;
    ack_dly = 0; z_word = '0; z_en = 1'b1;
    repeat (2) @(negedge clk);
    all_zero("reset_outputs");
    rst_n = 1'b1;
    #1 chk("ready_after_release", {79'd0, cmd_ready}, 80'd0);
    @(negedge clk);
    chk("ready_idle", {79'd0, cmd_ready}, 80'd1);

    for (int i = 0; i < 4; i++) begin
      start(vecs[i]);
      collect(vecs[i]);
      handoff(vecs[i]);
    end

    // result stalled while a new command waits
    start(vecs[0]);
    collect(vecs[0]);
    cmd_a = vecs[1].a; cmd_b = vecs[1].b; cmd_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_hold", {46'd0, cmd_ready, res_valid, res_z}, {46'd0, 2'b01, vecs[0].z});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("stall_release", {78'd0, res_valid, cmd_ready}, 80'd0);
    start(vecs[1]);
    collect(vecs[1]);
    handoff(vecs[1]);

    // core never answers: timeout appears exactly 20 cycles after accept, FSM keeps waiting in Z_HI
    v = '{32'h11112222, 32'h33334444, 32'h0, 0, 1'b1};
    start(v);
    z_en = 1'b0;
    repeat (19) @(negedge clk);
    chk("timeout_cycle19", {79'd0, timeout}, 80'd0);
    @(negedge clk);
    chk("timeout_cycle20", {79'd0, timeout}, 80'd1);
    repeat (5) @(negedge clk);
    chk("timeout_waiting", {77'd0, timeout, link_z_ack, res_valid}, {77'd0, 3'b110});
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset in the middle of the B_LO word
    start(vecs[0]);
    n = 0;
    while (rp != 3 && n < 50) begin @(negedge clk); n++; end
    chk("reach_b_lo", {79'd0, link_b_stb}, 80'd1);
    #2 rst_n = 1'b0;
    #1 all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_midreset", {79'd0, cmd_ready}, 80'd0);
    start(vecs[3]);
    collect(vecs[3]);
    handoff(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
